// File: rtl/alu_bist_if.sv
// ALU operand/response bundle between the BIST sequencer and the ALU under test.
//   data1, data2 : operands A and B
//   ALU_control  : operation code
//   ALU_result   : ALU output, combinational from the three signals above
//   Z            : ALU zero flag
// master = sequencer side, slave = ALU side.
interface alu_bist_if;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [3:0]  ALU_control;
  logic [31:0] ALU_result;
  logic        Z;

  modport master (
    output data1,
    output data2,
    output ALU_control,
    input  ALU_result,
    input  Z
  );

  modport slave (
    input  data1,
    input  data2,
    input  ALU_control,
    output ALU_result,
    output Z
  );
endinterface

// File: rtl/alu_bist.sv
// ALU built-in self-test sequencer.
// Sweeps ALU_control over 0..NUM_OPS-1 and applies VEC_PER_OP LFSR-generated operand pairs per code.
// Every ALU response is folded into a 32-bit MISR signature.
// Ports:
//   clk, rst             : clock and synchronous active-high reset
//   start, abort         : run request / cancel of a run in progress
//   alu                  : operand/control outputs and result/Z inputs (master side)
//   busy, done, pass     : run status; pass = done && signature == EXPECTED_SIG
//   signature, z_count   : current MISR value and saturating count of captures with Z=1
module alu_bist #(
  parameter int unsigned NUM_OPS      = 10,
  parameter int unsigned VEC_PER_OP   = 16,
  parameter logic [31:0] SEED_A       = 32'h0000_00C8,
  parameter logic [31:0] SEED_B       = 32'h0000_0064,
  parameter logic [31:0] EXPECTED_SIG = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  alu_bist_if.master        alu,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [31:0]       signature,
  output logic [15:0]       z_count
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [31:0] SeedAEff = (SEED_A == 32'h0) ? 32'h1 : SEED_A;
  localparam logic [31:0] SeedBEff = (SEED_B == 32'h0) ? 32'h1 : SEED_B;
  localparam logic [3:0]  LastOp   = 4'(NUM_OPS - 1);
  localparam logic [15:0] LastVec  = 16'(VEC_PER_OP - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StCapture, StDone} state_e;

  state_e      state_q;
  logic [31:0] data1_q;
  logic [31:0] data2_q;
  logic [3:0]  ctrl_q;
  logic [31:0] sig_q;
  logic [15:0] zcnt_q;
  logic [15:0] vec_q;
  logic        busy_q;
  logic        done_q;

  // Shared shift/feedback used by both operand LFSRs and the MISR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    return {cur[30:0], cur[31] ^ cur[21] ^ cur[1] ^ cur[0]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      data1_q <= 32'h0;
      data2_q <= 32'h0;
      ctrl_q  <= 4'h0;
      sig_q   <= 32'hFFFF_FFFF;
      zcnt_q  <= 16'h0;
      vec_q   <= 16'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort && busy_q) begin
      // Cancel: operands cleared, signature and z_count kept for inspection.
      state_q <= StIdle;
      data1_q <= 32'h0;
      data2_q <= 32'h0;
      ctrl_q  <= 4'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StDrive;
            data1_q <= SeedAEff;
            data2_q <= SeedBEff;
            ctrl_q  <= 4'h0;
            sig_q   <= 32'hFFFF_FFFF;
            zcnt_q  <= 16'h0;
            vec_q   <= 16'h0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        StDrive: begin
          state_q <= StCapture;
        end
        StCapture: begin
          sig_q <= lfsr_step(sig_q) ^ alu.ALU_result ^ {31'b0, alu.Z};
          if (alu.Z && (zcnt_q != 16'hFFFF)) begin
            zcnt_q <= zcnt_q + 16'h1;
          end
          if (vec_q != LastVec) begin
            vec_q   <= vec_q + 16'h1;
            data1_q <= lfsr_step(data1_q);
            data2_q <= lfsr_step(data2_q);
            state_q <= StDrive;
          end else if (ctrl_q != LastOp) begin
            vec_q   <= 16'h0;
            ctrl_q  <= ctrl_q + 4'h1;
            data1_q <= lfsr_step(data1_q);
            data2_q <= lfsr_step(data2_q);
            state_q <= StDrive;
          end else begin
            // Operands hold their last values in DONE.
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign alu.data1       = data1_q;
  assign alu.data2       = data2_q;
  assign alu.ALU_control = ctrl_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign signature       = sig_q;
  assign z_count         = zcnt_q;
  assign pass            = done_q && (sig_q == EXPECTED_SIG);

endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Synthesizable self-test sequencer that drives the ALU operand/control interface (data1, data2, ALU_control) and consumes its response (ALU_result, Z).
- Sweeps every ALU control code over a programmable number of pseudo-random operand vectors and compresses all results into a 32-bit MISR signature.
- Reports done, pass, signature and Z-count to the SoC debug/status path, giving on-silicon ALU checking without a simulator bench.

Parameters:
- NUM_OPS, 10, number of ALU_control codes swept (codes 0..NUM_OPS-1, max 16).
- VEC_PER_OP, 16, operand vectors applied per control code (1..65535).
- SEED_A, 32'h0000_00C8, initial data1 LFSR value (200).
- SEED_B, 32'h0000_0064, initial data2 LFSR value (100).
- EXPECTED_SIG, 32'h0000_0000, golden signature compared at end of run.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle request to begin a run.
- abort  in  1  synchronous abort of a run in progress.
- data1  out  32  ALU operand A, registered.
- data2  out  32  ALU operand B, registered.
- ALU_control  out  4  ALU operation code, registered.
- ALU_result  in  32  ALU result; combinational from data1/data2/ALU_control.
- Z  in  1  ALU zero flag.
- busy  out  1  high while a run is in progress.
- done  out  1  level; high after a completed run.
- pass  out  1  done && signature==EXPECTED_SIG.
- signature  out  32  current MISR value.
- z_count  out  16  number of captured vectors with Z=1.

Behaviour:
- Reset (rst=1 at clock edge), next cycle:
  - State IDLE.
  - data1, data2 and ALU_control are 0.
  - busy, done and pass are 0.
  - signature is 32'hFFFF_FFFF and z_count is 0.
- Reset wins over start and abort and takes effect mid-run. No partial results are retained.
- States: IDLE, DRIVE, CAPTURE, DONE.
  - IDLE/DONE + start=1: load data1=SEED_A, data2=SEED_B (a zero seed is replaced by 32'h1), ALU_control=0. Clear signature to FFFF_FFFF, z_count to 0, op/vector counters to 0, done to 0. Go to DRIVE.
  - DRIVE: operands stable for one full cycle. Go to CAPTURE.
  - CAPTURE: at the closing edge, perform the MISR update and z_count += Z. Then:
    - If the vector counter is below VEC_PER_OP-1: increment it, advance both LFSRs, go to DRIVE.
    - Else if ALU_control is below NUM_OPS-1: clear the vector counter, increment ALU_control, advance both LFSRs, go to DRIVE.
    - Else: go to DONE.
  - DONE: done=1, busy=0. data1, data2 and ALU_control hold their last values.
- Run timing:
  - busy=1 in DRIVE and CAPTURE.
  - Every vector takes exactly 2 cycles. A run takes 2*NUM_OPS*VEC_PER_OP cycles from the first DRIVE to DONE, which is 320 with the defaults.
  - done rises on the edge after the last CAPTURE.
- start while busy is ignored. start in DONE restarts the run from the seeds.
- abort in DRIVE or CAPTURE:
  - Next state is IDLE with busy=0 and done=0.
  - signature and z_count hold their values.
  - Operand outputs go to 0.
  - abort in IDLE or DONE has no effect.
  - abort and start in the same cycle: abort wins if busy, otherwise start wins.
- LFSR step, both operands: next = {cur[30:0], cur[31]^cur[21]^cur[1]^cur[0]}. LFSRs run continuously across op codes and are not reseeded per op.
- MISR step: sig_next = {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ ALU_result ^ {31'b0, Z}.
- z_count saturates at 16'hFFFF.
- pass is combinational from done and signature, and is 0 whenever done=0.

Test Plan:
- Defaults, real ALU, pulse start → ALU_control steps 0..9, each code held 32 cycles. The first vector is data1=200, data2=100 and the second is data1=0x190, data2=0xC8. done rises exactly 320 cycles after the first DRIVE. signature equals the bench reference-model MISR.
- Stub ALU (ALU_result=0, Z=1) → z_count=160 at done. signature equals the model MISR with input 1 each step. pass=1 when EXPECTED_SIG is set to that value, 0 otherwise.
- start pulsed again at cycle 100 of a run → no effect; done still at cycle 320. start in DONE → done drops the next cycle and data1 returns to 200.
- rst asserted at cycle 50 of a run → next cycle all outputs are at reset values and signature is FFFF_FFFF. A subsequent start reproduces the same final signature as an uninterrupted run.
- abort at cycle 61 → IDLE with busy=0 and done=0; signature holds its cycle-61 value. start+abort together in IDLE → run starts.
- NUM_OPS=1, VEC_PER_OP=1, SEED_A=0 → data1=1. done after 2 cycles. signature = one MISR step from FFFF_FFFF.
